// File: rtl/frame_sync_buffer.sv
// frame_sync_buffer: triple-register (back / shadow / front) frame buffer.
// The producer fills the back buffer and commits a frame. The display-side
// front buffer only changes at the start of vertical blanking, so the picture
// generator never sees a partially updated frame. IMMEDIATE=1 bypasses the
// vblank wait and promotes every commit straight to the front buffer.
module frame_sync_buffer #(
   parameter int             CH        = 10,
   parameter int             W         = 10,
   parameter logic [W-1:0]   RST_VAL   = '0,
   parameter int             IMMEDIATE = 0,
   parameter int             IW        = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_idx,
   input  logic [W-1:0]      wr_data,
   input  logic              commit,
   input  logic              vs_n,
   output logic [CH*W-1:0]   front_data,
   output logic              pending,
   output logic              swap,
   output logic [7:0]        drop_cnt
);

   logic [W-1:0]  back_q   [CH];
   logic [W-1:0]  shadow_q [CH];
   logic [W-1:0]  front_q  [CH];
   logic [W-1:0]  snap     [CH];
   logic [CH-1:0] wr_hit;
   logic          vs_q;
   logic          vb_start;
   logic          promote;

   assign vb_start = vs_q & ~vs_n;
   assign promote  = vb_start & pending;

   // Decode the write index; out-of-range indices match no channel.
   // The snapshot merges a same-cycle write so commit captures it.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         wr_hit[i] = wr_en && (int'(wr_idx) == i);
         snap[i]   = wr_hit[i] ? wr_data : back_q[i];
      end
   end

   // Flatten the front buffer, channel i at bits [i*W +: W].
   always_comb begin
      front_data = '0;
      for (int i = 0; i < CH; i++) begin
         front_data[i*W +: W] = front_q[i];
      end
   end

   // Buffer storage, commit/promotion sequencing and drop accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            back_q[i]   <= RST_VAL;
            shadow_q[i] <= RST_VAL;
            front_q[i]  <= RST_VAL;
         end
         pending  <= 1'b0;
         swap     <= 1'b0;
         drop_cnt <= 8'd0;
         vs_q     <= 1'b1;
      end else begin
         vs_q <= vs_n;
         swap <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            if (wr_hit[i]) back_q[i] <= wr_data;
         end
         if (IMMEDIATE != 0) begin
            // Bypass: every commit goes straight to the display.
            if (commit) begin
               for (int i = 0; i < CH; i++) begin
                  shadow_q[i] <= snap[i];
                  front_q[i]  <= snap[i];
               end
               swap <= 1'b1;
            end
         end else begin
            if (promote) begin
               for (int i = 0; i < CH; i++) begin
                  front_q[i] <= shadow_q[i];
               end
               swap <= 1'b1;
            end
            if (commit) begin
               for (int i = 0; i < CH; i++) begin
                  shadow_q[i] <= snap[i];
               end
               pending <= 1'b1;
               // A same-cycle promotion consumes the old shadow, so no drop.
               if (pending && !promote && drop_cnt != 8'hFF) begin
                  drop_cnt <= drop_cnt + 8'd1;
               end
            end else if (promote) begin
               pending <= 1'b0;
            end
         end
      end
   end

endmodule
